// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-to-1 channel mux feeding a single registered output stage.
// The channel is picked by an external select (MODE 0) or round-robin (MODE 1).
module mux_nx1_pipe #(
    parameter int WIDTH = 5,
    parameter int N     = 2,
    parameter int MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [$clog2(N)-1:0] sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_chan,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          xfer_cnt
);
    localparam int SW = $clog2(N);

    logic             w_can_load;
    logic             w_hit;
    logic [SW-1:0]    w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_din;
    logic [SW-1:0]    w_ptr_nxt;

    logic [SW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_chan;
    logic             r_valid;
    logic [15:0]      r_cnt;

    assign w_can_load = !r_valid || out_ready;

    // Candidate channel: external select, or first valid searching from ptr
    always_comb begin
        int j;
        w_hit = 1'b0;
        w_idx = '0;
        j     = 0;
        if (MODE == 0) begin
            if (int'(sel) < N) begin
                w_hit = 1'b1;
                w_idx = sel;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = int'(r_ptr) + k;
                if (j >= N) begin
                    j = j - N;
                end
                if (!w_hit && in_valid[SW'(j)]) begin
                    w_hit = 1'b1;
                    w_idx = SW'(j);
                end
            end
        end
    end

    // One-hot ready at the candidate, gated by output space and reset
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_hit && w_can_load && rst_n
                          && (w_idx == SW'(i));
        end
    end

    // Data word of the candidate channel
    always_comb begin
        w_din = '0;
        for (int i = 0; i < N; i++) begin
            if (w_idx == SW'(i)) begin
                w_din = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer    = |(in_valid & in_ready);
    assign w_ptr_nxt = (w_idx == SW'(N - 1)) ? '0 : w_idx + SW'(1);

    // Output register, round-robin pointer and transfer counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_xfer) begin
                r_data  <= w_din;
                r_chan  <= w_idx;
                r_valid <= 1'b1;
                r_cnt   <= r_cnt + 16'd1;
                r_ptr   <= w_ptr_nxt;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;
    assign xfer_cnt  = r_cnt;

endmodule

// File: doc/mux_nx1_pipe.md
MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning the data width per channel in bits.
REQ-002 The block SHALL have parameter N, default 2, meaning the number of input channels; legal range 2..16.
REQ-003 The block SHALL have parameter MODE, default 0, meaning 0 = external select and 1 = round-robin arbitration.
REQ-004 The block SHALL have port clk  input  1  the single clock, rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid  input  N  per-channel valid.
REQ-008 The block SHALL have port in_ready  output  N  per-channel ready, combinational.
REQ-009 The block SHALL have port sel  input  SW=clog2(N)  channel select, used in MODE 0 only.
REQ-010 The block SHALL have port out_data  output  WIDTH  registered selected data.
REQ-011 The block SHALL have port out_chan  output  SW  index of the channel that supplied out_data.
REQ-012 The block SHALL have port out_valid  output  1  the output register holds data.
REQ-013 The block SHALL have port out_ready  input  1  the consumer accepts out_data this cycle.
REQ-014 The block SHALL have port xfer_cnt  output  16  count of input transfers, wraps at 2^16.

Function
REQ-015 The output stage SHALL be one register; can_load = !out_valid | out_ready.
REQ-016 An input transfer on channel c SHALL occur iff in_valid[c] & in_ready[c]; at most one in_ready bit SHALL be 1 per cycle.
REQ-017 In MODE 0, in_ready[i] SHALL equal (i==sel) & can_load; if sel >= N, all in_ready SHALL be 0 and no transfer SHALL occur.
REQ-018 In MODE 1, the granted channel SHALL be the first i with in_valid[i]=1, searching ptr, ptr+1, ... mod N; in_ready SHALL be 1 only at that index, gated by can_load; sel SHALL be ignored.
REQ-019 In MODE 1, ptr SHALL update to (c+1) mod N on a transfer from channel c and SHALL hold otherwise; the wrap from N-1 to 0 SHALL be correct for non-power-of-two N.
REQ-020 On a transfer, the next edge SHALL load out_data=in_data[c], out_chan=c, out_valid=1 (latency one cycle).
REQ-021 If out_valid & out_ready and no transfer occurs, out_valid SHALL clear next edge; out_data and out_chan SHALL hold their value.
REQ-022 Simultaneous drain and transfer SHALL load the new word with out_valid staying 1, giving full throughput of one word per cycle.
REQ-023 While out_valid & !out_ready, out_data and out_chan SHALL remain stable and all in_ready SHALL be 0.
REQ-024 xfer_cnt SHALL increment by 1 per transfer and SHALL wrap from 16'hFFFF to 0.
REQ-025 Combinational paths SHALL run only from in_valid, sel, out_valid and out_ready to in_ready; out_* SHALL be registered.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force out_valid=0, out_data=0, out_chan=0, ptr=0 and xfer_cnt=0, independent of clk.
REQ-027 While rst_n=0, all in_ready SHALL be 0.
REQ-028 A reset during operation SHALL discard any held word; the first transfer after reset release SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-029 With MODE0, WIDTH=5, N=2, sel=1, in_data={5'h1A,5'h03}, both valid and out_ready=1 -> in_ready=2'b10; after one edge out_data=5'h1A, out_chan=1, out_valid=1.
REQ-030 In MODE0, hold out_ready=0 for 3 cycles with out_valid=1 -> out_data is stable, in_ready=0 and xfer_cnt is unchanged; release -> a new word loads on the same edge.
REQ-031 With MODE1, N=4, in_valid=4'b1111 and out_ready=1 for 5 cycles -> out_chan sequence is 0,1,2,3,0 and xfer_cnt=5.
REQ-032 With MODE1, N=3, in_valid=3'b101 and ptr=1 -> channel 2 is granted, then ptr=0 and channel 0 is granted next (the wrap case).
REQ-033 With MODE0, N=3 and sel=3 -> in_ready=0 and out_valid stays 0.
REQ-034 Assert rst_n=0 between clock edges while out_valid=1 -> out_valid, out_data and xfer_cnt are 0 before the next edge.
